// File: rtl/maxpool_pkg.sv
// Shared types and default sizing for the serial max-pool window sequencer.
package maxpool_pkg;

  localparam int unsigned N_DEF = 8;
  localparam int unsigned K_DEF = 8;
  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/maxpool_acc.sv
// Running-max accumulator: load overwrites, enable keeps the larger (unsigned) value.
module maxpool_acc #(
  parameter int unsigned N = maxpool_pkg::N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en && (d > q)) begin
      q <= d;
    end
  end

endmodule

// File: rtl/maxpool_window_ctrl.sv
// Groups an element stream into K-element windows, emits one max per window,
// and pulses done after a programmable number of windows.
module maxpool_window_ctrl
  import maxpool_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned K = K_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] num_win,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_ELEM = CW'(K - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] elem_cnt;
  logic [W-1:0]  win_cnt;
  logic [W-1:0]  num_win_q;
  logic          accept;
  logic          last_elem;
  logic          last_win;
  logic          acc_load;
  logic          acc_en;

  assign accept    = in_valid && in_ready;
  assign last_elem = (elem_cnt == LAST_ELEM);
  assign last_win  = (win_cnt == (num_win_q - W'(1)));
  assign acc_load  = accept && (elem_cnt == '0);
  assign acc_en    = accept && (elem_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_win != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (accept && last_elem) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_next = last_win ? DONE : ACCUM;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == EMIT);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem_cnt  <= '0;
      win_cnt   <= '0;
      num_win_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (num_win != '0)) begin
            num_win_q <= num_win;
            elem_cnt  <= '0;
            win_cnt   <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            elem_cnt <= last_elem ? '0 : elem_cnt + CW'(1);
          end
        end
        EMIT: begin
          if (out_ready && !last_win) begin
            win_cnt <= win_cnt + W'(1);
          end
        end
        DONE:    win_cnt <= '0;
        default: ;
      endcase
    end
  end

  // acc only changes while accepting, so q doubles as the held result in EMIT.
  maxpool_acc #(
    .N(N)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .load (acc_load),
    .en   (acc_en),
    .d    (in_data),
    .q    (out_data)
  );

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Scoreboard bench for maxpool_window_ctrl with directed windows and hand-computed maxima.
module tb_maxpool_window_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_win = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic done_prev = 1'b0;
  logic [7:0] exp_q [$];

  maxpool_window_ctrl #(
    .N(8),
    .K(8),
    .W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_win   (num_win),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and tracks done pulses.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (done_prev) check("done_width", 32'd2, 32'd1);
    end
    done_prev = (done === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic do_start(input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    num_win = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_elem(input logic [7:0] d, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_window(input logic [7:0] w [8], input int gap_mode);
    for (int i = 0; i < 8; i++) begin
      send_elem(w[i], (gap_mode == 1) ? 2 : (gap_mode == 2) ? (i % 2) : 0);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt != exp_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("done_count", 32'(done_cnt), 32'(exp_done));
  endtask

  logic [7:0] w [8];

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // 1: single window
    do_start(8'd1);
    exp_q.push_back(8'd99);
    exp_done++;
    w = '{8'd29, 8'd34, 8'd39, 8'd23, 8'd99, 8'd78, 8'd0, 8'd87};
    send_window(w, 0);
    @(negedge clk);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_out_data", 32'(out_data), 99);
    @(negedge clk);
    check("t1_valid_drop", 32'(out_valid), 0);
    check("t1_done", 32'(done), 1);
    check("t1_busy_done", 32'(busy), 1);
    @(negedge clk);
    check("t1_done_low", 32'(done), 0);
    check("t1_busy_low", 32'(busy), 0);
    wait_done();

    // 2: three windows
    do_start(8'd3);
    exp_q.push_back(8'd8);
    exp_q.push_back(8'd200);
    exp_q.push_back(8'd0);
    exp_done++;
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_window(w, 0);
    w = '{8'd200, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    send_window(w, 0);
    w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_window(w, 0);
    wait_done();

    // 3: backpressure
    out_ready = 1'b0;
    do_start(8'd2);
    exp_q.push_back(8'd77);
    exp_q.push_back(8'd5);
    exp_done++;
    w = '{8'd10, 8'd77, 8'd12, 8'd76, 8'd1, 8'd128, 8'd2, 8'd3};
    w[5] = 8'd70;
    send_window(w, 0);
    in_valid = 1'b1;
    in_data = 8'd250;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_data", 32'(out_data), 77);
      check("t3_hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    w = '{8'd1, 8'd5, 8'd2, 8'd4, 8'd3, 8'd0, 8'd5, 8'd1};
    send_window(w, 0);
    wait_done();

    // 4: input gaps, ties
    do_start(8'd2);
    exp_q.push_back(8'd255);
    exp_q.push_back(8'd50);
    exp_done++;
    w = '{8'd255, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
    send_window(w, 1);
    w = '{8'd50, 8'd50, 8'd20, 8'd50, 8'd10, 8'd50, 8'd0, 8'd50};
    send_window(w, 2);
    wait_done();

    // 5: zero-window job, start while busy
    do_start(8'd0);
    exp_done++;
    @(negedge clk);
    check("t5_done", 32'(done), 1);
    check("t5_busy", 32'(busy), 1);
    check("t5_no_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("t5_done_low", 32'(done), 0);
    check("t5_idle", 32'(busy), 0);
    wait_done();
    do_start(8'd1);
    exp_q.push_back(8'd130);
    exp_done++;
    w = '{8'd127, 8'd128, 8'd129, 8'd130, 8'd4, 8'd5, 8'd6, 8'd7};
    for (int i = 0; i < 8; i++) begin
      send_elem(w[i], 0);
      if (i == 3) begin
        start = 1'b1;
        num_win = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    wait_done();
    repeat (4) @(negedge clk);
    check("t5_no_queued_job", 32'(busy), 0);
    check("t5_done_total", 32'(done_cnt), 32'(exp_done));

    // 6: async reset mid-window
    do_start(8'd1);
    send_elem(8'd200, 0);
    send_elem(8'd201, 0);
    send_elem(8'd202, 0);
    #3 rst = 1'b0;
    #1;
    check("t6_in_ready", 32'(in_ready), 0);
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_out_data", 32'(out_data), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_abort_done", 32'(done_cnt), 32'(exp_done));
    do_start(8'd1);
    exp_q.push_back(8'd8);
    exp_done++;
    w = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4};
    send_window(w, 0);
    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
